// File: rtl/pwm_capture.sv
// Purpose : recover the 8-bit power code from the duty cycle of a PWM line, and check the period and loss of the line.
// Latency : about 4 clocks from a pwm_in edge to power/valid (2 sync flops, edge detect, output register).
// Backpr. : none; valid is a one-clock strobe that the consumer must take when it is high.
//
// Ports:
//   clock      system clock
//   reset      synchronous, active-high
//   pwm_in     asynchronous PWM input
//   power      last accepted duty code (0 or 255 while the line is stuck)
//   valid      one-clock strobe whenever power/lost/period_err are updated
//   lost       no rising edge seen for TIMEOUT clocks
//   period_err last completed period was outside PERIOD +/- TOLERANCE
module pwm_capture #(
   parameter int unsigned STEP_DELAY = 195,     // clocks per power LSB
   parameter int unsigned PERIOD     = 50_000,  // nominal period in clocks
   parameter int unsigned TOLERANCE  = 500,     // accepted period deviation
   parameter int unsigned TIMEOUT    = 100_000  // clocks without a rise => lost (< 2^17)
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       pwm_in,
   output logic [7:0] power,
   output logic       valid,
   output logic       lost,
   output logic       period_err
);

   localparam int unsigned      PRE_W       = (STEP_DELAY > 1) ? $clog2(STEP_DELAY) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(STEP_DELAY - 1);
   localparam logic [PRE_W-1:0] PRE_ONE     = PRE_W'(1);
   localparam logic [16:0]      TIMEOUT_CNT = 17'(TIMEOUT);
   localparam logic [31:0]      P_MIN       = (PERIOD > TOLERANCE) ? PERIOD - TOLERANCE : 32'd0;
   localparam logic [31:0]      P_MAX       = PERIOD + TOLERANCE;

   typedef enum logic [1:0] {
      WAIT_RISE = 2'd0,
      MEAS_HIGH = 2'd1,
      MEAS_LOW  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             s1_q, s1_d;
   logic             s2_q, s2_d;
   logic             s3_q, s3_d;
   logic [1:0]       fill_q, fill_d;
   logic [16:0]      per_cnt_q, per_cnt_d;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic [7:0]       steps_q, steps_d;
   logic [7:0]       held_q, held_d;
   logic [7:0]       power_q, power_d;
   logic             valid_q, valid_d;
   logic             lost_q, lost_d;
   logic             err_q, err_d;

   logic             edge_ok;
   logic             rise;
   logic             fall;
   logic             per_in_tol;
   logic [PRE_W-1:0] pre_base;
   logic [7:0]       steps_base;

   // After reset the sync chain is all zero while the line may already be
   // high; comparing s2 against a cleared s3 would invent a rise out of the
   // reset itself and publish a partial period. Edges are only trusted once
   // s1..s3 have all been refilled from the line.
   assign edge_ok    = (fill_q == 2'd3);
   assign rise       = edge_ok &  s2_q & ~s3_q;
   assign fall       = edge_ok & ~s2_q &  s3_q;
   assign per_in_tol = ({15'd0, per_cnt_q} >= P_MIN) && ({15'd0, per_cnt_q} <= P_MAX);

   always_comb begin
      s1_d       = pwm_in;
      s2_d       = s1_q;
      s3_d       = s2_q;
      fill_d     = (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;
      state_d    = state_q;
      per_cnt_d  = (per_cnt_q == TIMEOUT_CNT) ? per_cnt_q : per_cnt_q + 17'd1;
      pre_d      = pre_q;
      steps_d    = steps_q;
      held_d     = held_q;
      power_d    = power_q;
      valid_d    = 1'b0;
      lost_d     = lost_q;
      err_d      = err_q;

      // The rise cycle is the first high cycle: it counts from cleared
      // counters rather than from whatever the previous period left behind.
      pre_base   = rise ? '0    : pre_q;
      steps_base = rise ? 8'd0  : steps_q;

      if (rise || (state_q == MEAS_HIGH && s2_q)) begin
         if (pre_base == PRE_LAST) begin
            pre_d   = '0;
            steps_d = (steps_base == 8'hFF) ? 8'hFF : steps_base + 8'd1;
         end else begin
            pre_d   = pre_base + PRE_ONE;
            steps_d = steps_base;
         end
      end

      if (rise) begin
         // A rise exactly at the timeout still closes a real period, so it
         // takes priority over declaring the line lost.
         per_cnt_d = 17'd1;
         state_d   = MEAS_HIGH;
         if (state_q == MEAS_LOW) begin
            valid_d = 1'b1;
            if (per_in_tol) begin
               power_d = held_q;
               lost_d  = 1'b0;
               err_d   = 1'b0;
            end else begin
               err_d   = 1'b1;
            end
         end
      end else if (per_cnt_q == TIMEOUT_CNT) begin
         // Stuck line: report full or zero power from the level it is stuck
         // at, then rearm so this repeats every TIMEOUT clocks.
         power_d   = s2_q ? 8'hFF : 8'h00;
         lost_d    = 1'b1;
         err_d     = 1'b0;
         valid_d   = 1'b1;
         per_cnt_d = 17'd1;
         state_d   = WAIT_RISE;
      end else if (fall && state_q == MEAS_HIGH) begin
         state_d = MEAS_LOW;
         held_d  = steps_d;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= WAIT_RISE;
         s1_q      <= 1'b0;
         s2_q      <= 1'b0;
         s3_q      <= 1'b0;
         fill_q    <= 2'd0;
         per_cnt_q <= 17'd0;
         pre_q     <= '0;
         steps_q   <= 8'd0;
         held_q    <= 8'd0;
         power_q   <= 8'd0;
         valid_q   <= 1'b0;
         lost_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         s3_q      <= s3_d;
         fill_q    <= fill_d;
         per_cnt_q <= per_cnt_d;
         pre_q     <= pre_d;
         steps_q   <= steps_d;
         held_q    <= held_d;
         power_q   <= power_d;
         valid_q   <= valid_d;
         lost_q    <= lost_d;
         err_q     <= err_d;
      end
   end

   assign power      = power_q;
   assign valid      = valid_q;
   assign lost       = lost_q;
   assign period_err = err_q;

endmodule

// File: tb/tb_pwm_capture.sv
module tb_pwm_capture;

   // Scaled-down timing so whole periods fit in a short run:
   // 256 codes * 4 clocks = 1024-clock period.
   localparam int SD  = 4;
   localparam int PER = 1024;
   localparam int TOL = 16;
   localparam int TO  = 2048;

   logic       clock = 1'b0;
   logic       reset;
   logic       pwm_in;
   logic [7:0] power;
   logic       valid;
   logic       lost;
   logic       period_err;

   pwm_capture #(
      .STEP_DELAY(SD),
      .PERIOD    (PER),
      .TOLERANCE (TOL),
      .TIMEOUT   (TO)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .pwm_in    (pwm_in),
      .power     (power),
      .valid     (valid),
      .lost      (lost),
      .period_err(period_err)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [7:0] power;
      logic       lost;
      logic       err;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model state, in input-cycle time (tnow = index of the clock
   // edge that samples the currently driven level).
   int         tnow      = 0;
   logic       cur_lvl   = 1'b0;
   bit         armed     = 1'b0;   // a rise has started a measured period
   bit         seen_fall = 1'b0;   // that period has entered its low phase
   int         r_t       = 0;      // time of the last rise
   int         ref_t     = 0;      // start of the current timeout window
   int         held_m    = 0;
   logic [7:0] m_power   = 8'd0;
   logic       m_lost    = 1'b0;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic push_exp(input logic [7:0] p, input logic l, input logic e);
      exp_t x;
      x.power = p;
      x.lost  = l;
      x.err   = e;
      exp_q.push_back(x);
   endtask

   // Every TO cycles without a rise the line is reported lost at its current level.
   task automatic model_timeouts(input int t);
      while (ref_t + TO < t) begin
         ref_t     = ref_t + TO;
         m_power   = cur_lvl ? 8'd255 : 8'd0;
         m_lost    = 1'b1;
         armed     = 1'b0;
         seen_fall = 1'b0;
         push_exp(m_power, 1'b1, 1'b0);
      end
   endtask

   task automatic model_rise(input int t);
      int p;
      if (armed && seen_fall) begin
         p = t - r_t;
         if (p >= PER - TOL && p <= PER + TOL) begin
            m_power = 8'(held_m);
            m_lost  = 1'b0;
            push_exp(m_power, 1'b0, 1'b0);
         end else begin
            push_exp(m_power, m_lost, 1'b1);
         end
      end
      armed     = 1'b1;
      seen_fall = 1'b0;
      r_t       = t;
      ref_t     = t;
   endtask

   task automatic model_fall(input int t);
      if (armed) begin
         held_m = (t - r_t) / SD;
         if (held_m > 255) held_m = 255;
         seen_fall = 1'b1;
      end
   endtask

   task automatic drive_lvl(input logic lvl, input int n);
      for (int i = 0; i < n; i++) begin
         model_timeouts(tnow);
         if (lvl && !cur_lvl)      model_rise(tnow);
         else if (!lvl && cur_lvl) model_fall(tnow);
         cur_lvl = lvl;
         pwm_in  = lvl;
         @(posedge clock);
         #1;
         tnow++;
      end
   endtask

   task automatic drive_period(input int h, input int p);
      drive_lvl(1'b1, h);
      drive_lvl(1'b0, p - h);
   endtask

   task automatic reset_pulse();
      model_timeouts(tnow);
      armed     = 1'b0;
      seen_fall = 1'b0;
      ref_t     = tnow;
      m_power   = 8'd0;
      m_lost    = 1'b0;
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      tnow++;
      check("midrst_power", power, 0);
      check("midrst_valid", valid, 0);
      check("midrst_lost", lost, 0);
      check("midrst_period_err", period_err, 0);
   endtask

   // Monitor: every valid strobe must match the oldest expected update.
   always @(negedge clock) begin
      if (!reset && valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid power=%0d lost=%0d period_err=%0d required=no update (t=%0t)",
                     power, lost, period_err, $time);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("power", power, e.power);
            check("lost", lost, e.lost);
            check("period_err", period_err, e.err);
         end
      end
   end

   initial begin
      #10_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int p;
      int h;
      reset  = 1'b1;
      pwm_in = 1'b0;
      repeat (5) @(posedge clock);
      #1;
      check("rst_power", power, 0);
      check("rst_valid", valid, 0);
      check("rst_lost", lost, 0);
      check("rst_period_err", period_err, 0);
      reset = 1'b0;
      drive_lvl(1'b0, 10);

      // Lock at half power; the first period is only a reference.
      repeat (3) drive_period(512, PER);
      // Full scale, just under one LSB, exactly one LSB, then code 64.
      drive_period(1020, PER);
      drive_period(3, PER);
      drive_period(4, PER);
      drive_period(256, PER);
      // Short period is flagged and keeps code 64; then a good code 10.
      drive_period(40, 819);
      drive_period(40, PER);
      // Tolerance edges: inside, inside, outside, outside.
      drive_period(100, PER + TOL);
      drive_period(200, PER - TOL);
      drive_period(300, PER + TOL + 1);
      drive_period(400, PER - TOL - 1);
      // High time beyond 255 codes saturates.
      drive_period(PER + TOL - 4, PER + TOL);
      // Rise landing exactly on the timeout closes a (bad) period instead.
      drive_period(100, TO);
      drive_period(256, PER);

      // Line stuck low for 2.5 timeouts, then recovery.
      drive_period(256, 256 + 5120);
      drive_period(256, PER);
      drive_period(256, PER);
      // Line stuck high, then recovery.
      drive_period(5120, 5376);
      drive_period(256, PER);
      drive_period(256, PER);

      // Reset in the middle of a high phase at code 200.
      drive_period(800, PER);
      drive_period(800, PER);
      drive_lvl(1'b1, 400);
      reset_pulse();
      drive_lvl(1'b1, 399);
      drive_lvl(1'b0, 624);
      repeat (3) drive_period(800, PER);

      // Random duty and period jitter around nominal.
      repeat (20) begin
         p = PER - 40 + int'($urandom_range(80));
         h = int'($urandom_range(p - 1, 1));
         drive_period(h, p);
      end

      drive_period(512, PER);
      repeat (20) @(posedge clock);
      #1;
      check("pending_updates", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
